// File: rtl/nios_system_pll_reset_ctrl_if.sv
// ----------------------------------------------------------------------------
// nios_system_pll_reset_ctrl_if
// Signal bundle between the PLL reset controller and the system around it.
//   pll_locked    : PLL lock indication, asynchronous to refclk
//   force_relock  : synchronous pulse that restarts the PLL sequence
//   pll_rst       : active-high reset to the PLL
//   sys_reset_n   : active-low reset to the downstream system
//   lock_ok       : high while the system is running on a locked PLL
//   fail          : high once lock could not be obtained within the retries
//   relock_count  : number of lock losses seen while running (saturating)
// Modports: master = system/PLL side, slave = controller.
// ----------------------------------------------------------------------------
interface nios_system_pll_reset_ctrl_if;

    localparam int unsigned RELOCK_W = 8;

    logic                pll_locked;
    logic                force_relock;
    logic                pll_rst;
    logic                sys_reset_n;
    logic                lock_ok;
    logic                fail;
    logic [RELOCK_W-1:0] relock_count;

    modport master (
        output pll_locked,
        output force_relock,
        input  pll_rst,
        input  sys_reset_n,
        input  lock_ok,
        input  fail,
        input  relock_count
    );

    modport slave (
        input  pll_locked,
        input  force_relock,
        output pll_rst,
        output sys_reset_n,
        output lock_ok,
        output fail,
        output relock_count
    );

endinterface

// File: rtl/nios_system_pll_reset_ctrl.sv
// ----------------------------------------------------------------------------
// nios_system_pll_reset_ctrl
// Reset sequencer and lock supervisor for the system PLL. Pulses the PLL
// reset, waits for a stable synchronized lock (retrying on timeout), releases
// the system reset only after lock has been continuously stable, and restarts
// the sequence on loss of lock or on a forced relock request.
// Ports:
//   refclk : reference clock, the only clock of this block
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of nios_system_pll_reset_ctrl_if (lock input,
//            force request, PLL/system resets and status outputs)
// ----------------------------------------------------------------------------
module nios_system_pll_reset_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                          refclk,
    input  logic                          rst_n,
    nios_system_pll_reset_ctrl_if.slave   bus
);

    localparam int unsigned RELOCK_W = 8;
    localparam int unsigned RETRY_W  = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]    RST_LAST     = CNT_W'(RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0]    STABLE_LAST  = CNT_W'(LOCK_STABLE - 32'd1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX    = RETRY_W'(MAX_RETRIES);
    localparam logic [RELOCK_W-1:0] RELOCK_MAX   = {RELOCK_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, lk_s_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cnt_clr;
    logic                force_take;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                pll_rst_q, pll_rst_d;
    logic                sys_reset_n_q, sys_reset_n_d;
    logic                lock_ok_q, lock_ok_d;
    logic                fail_q, fail_d;

    // Two-flop synchronizer for the asynchronous lock input.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            lk_s_q  <= 1'b0;
        end else begin
            sync1_q <= bus.pll_locked;
            lk_s_q  <= sync1_q;
        end
    end

    // State register.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, retry and relock bookkeeping.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        relock_d   = relock_q;
        force_take = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_PLL_RST;
            end
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk_s_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_PLL_RST;
                    end
                end
            end
            ST_STABLE: begin
                // A dropout restarts the stability window but keeps the retry budget.
                if (!lk_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                if (!lk_s_q) begin
                    state_d = ST_PLL_RST;
                    if (relock_q != RELOCK_MAX) begin
                        relock_d = relock_q + RELOCK_W'(1);
                    end
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Forced relock overrides every other transition but leaves relock_d alone,
        // so a simultaneous lock loss is still counted.
        if (bus.force_relock && (state_q != ST_IDLE)) begin
            state_d    = ST_PLL_RST;
            retry_d    = '0;
            force_take = 1'b1;
        end

        cnt_clr = (state_d != state_q) || force_take;
    end

    // Outputs decoded from the next state, registered below.
    always_comb begin
        pll_rst_d     = 1'b0;
        sys_reset_n_d = 1'b0;
        lock_ok_d     = 1'b0;
        fail_d        = 1'b0;
        unique case (state_d)
            ST_IDLE, ST_PLL_RST: begin
                pll_rst_d = 1'b1;
            end
            ST_RUN: begin
                sys_reset_n_d = 1'b1;
                lock_ok_d     = 1'b1;
            end
            ST_FAIL: begin
                fail_d = 1'b1;
            end
            default: begin
                pll_rst_d = 1'b0;
            end
        endcase
    end

    // Shared cycle counter, cleared on every state entry; saturates so long
    // stays in RUN/FAIL never wrap back into a compare value.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Retry and relock counters.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q  <= '0;
            relock_q <= '0;
        end else begin
            retry_q  <= retry_d;
            relock_q <= relock_d;
        end
    end

    // Output registers; the PLL is held in reset while rst_n is low.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            lock_ok_q     <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= sys_reset_n_d;
            lock_ok_q     <= lock_ok_d;
            fail_q        <= fail_d;
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_reset_n  = sys_reset_n_q;
    assign bus.lock_ok      = lock_ok_q;
    assign bus.fail         = fail_q;
    assign bus.relock_count = relock_q;

endmodule

// File: tb/tb_nios_system_pll_reset_ctrl.sv
// ----------------------------------------------------------------------------
// tb_nios_system_pll_reset_ctrl
// Self-checking bench for nios_system_pll_reset_ctrl. Expected latencies are
// derived from the sequencing rules (reset length, synchronizer depth,
// stability window, timeout, retry budget); relock_count is tracked by a
// simple saturating loss counter. Lock timing is randomized with $urandom.
// ----------------------------------------------------------------------------
module tb_nios_system_pll_reset_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRIES  = 2;
    // Lock rise to system release: two synchronizer edges, stability window, one register edge.
    localparam int BRING        = 2 + LOCK_STABLE + 1;
    // Lock fall to system reset: two synchronizer edges plus one register edge.
    localparam int DROP         = 3;

    localparam int SEL_PLL_RST = 0;
    localparam int SEL_SYS     = 1;
    localparam int SEL_FAIL    = 2;
    localparam int SEL_RSTFAIL = 3;

    logic refclk = 1'b0;
    logic rst_n;

    nios_system_pll_reset_ctrl_if bus ();

    nios_system_pll_reset_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (16)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    int checks     = 0;
    int errors     = 0;
    int relock_exp = 0;

    function automatic logic pick(input int sel);
        case (sel)
            SEL_PLL_RST: return bus.pll_rst;
            SEL_SYS:     return bus.sys_reset_n;
            SEL_FAIL:    return bus.fail;
            default:     return bus.pll_rst | bus.fail;
        endcase
    endfunction

    // Counts negedges until the selected signal shows val; -1 if the budget runs out.
    task automatic wait_sig(input int sel, input logic val, input int budget, output int n);
        n = 0;
        while (pick(sel) !== val) begin
            if (n >= budget) begin
                n = -1;
                return;
            end
            @(negedge refclk);
            n++;
        end
    endtask

    // From the first PLL_RST cycle: wait for pll_rst to fall, raise lock k cycles later,
    // then wait for system release (counted from the lock rise).
    task automatic run_to_lock(input int k, output int n_low, output int n_sys);
        wait_sig(SEL_PLL_RST, 1'b0, 50, n_low);
        repeat (k) @(negedge refclk);
        bus.pll_locked = 1'b1;
        wait_sig(SEL_SYS, 1'b1, 60, n_sys);
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.pll_locked   = 1'b0;
        bus.force_relock = 1'b0;
        repeat (3) @(negedge refclk);
        checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got %b exp 1", bus.pll_rst); end
        checks++; if (bus.sys_reset_n !== 1'b0) begin errors++; $display("FAIL reset_sys_reset_n got %b exp 0", bus.sys_reset_n); end
        checks++; if (bus.lock_ok !== 1'b0) begin errors++; $display("FAIL reset_lock_ok got %b exp 0", bus.lock_ok); end
        checks++; if (bus.fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b exp 0", bus.fail); end
        checks++; if (bus.relock_count !== 8'd0) begin errors++; $display("FAIL reset_relock got %0d exp 0", bus.relock_count); end
    endtask

    task automatic test_nominal();
        int n;
        int k;
        rst_n = 1'b1;
        wait_sig(SEL_PLL_RST, 1'b0, 50, n);
        checks++; if (n !== 1 + RST_CYCLES) begin errors++; $display("FAIL nominal_pll_rst_len got %0d exp %0d", n, 1 + RST_CYCLES); end
        k = int'($urandom_range(2, 15));
        repeat (k) @(negedge refclk);
        bus.pll_locked = 1'b1;
        wait_sig(SEL_SYS, 1'b1, 60, n);
        checks++; if (n !== BRING) begin errors++; $display("FAIL nominal_release got %0d exp %0d", n, BRING); end
        checks++; if (bus.lock_ok !== 1'b1) begin errors++; $display("FAIL nominal_lock_ok got %b exp 1", bus.lock_ok); end
        checks++; if (bus.fail !== 1'b0 || bus.pll_rst !== 1'b0) begin errors++; $display("FAIL nominal_fail_rst got %b%b exp 00", bus.fail, bus.pll_rst); end
    endtask

    task automatic test_loss_of_lock();
        int n;
        int n_low;
        int n_sys;
        for (int i = 0; i < 3; i++) begin
            repeat (int'($urandom_range(1, 6))) @(negedge refclk);
            bus.pll_locked = 1'b0;
            wait_sig(SEL_SYS, 1'b0, 10, n);
            relock_exp = (relock_exp < 255) ? relock_exp + 1 : 255;
            checks++; if (n !== DROP) begin errors++; $display("FAIL lol_sys_fall got %0d exp %0d", n, DROP); end
            checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL lol_pll_rst_rise got %b exp 1", bus.pll_rst); end
            checks++; if (int'(bus.relock_count) !== relock_exp) begin errors++; $display("FAIL lol_relock got %0d exp %0d", bus.relock_count, relock_exp); end
            run_to_lock(int'($urandom_range(0, 15)), n_low, n_sys);
            checks++; if (n_low !== RST_CYCLES) begin errors++; $display("FAIL lol_pll_rst_len got %0d exp %0d", n_low, RST_CYCLES); end
            checks++; if (n_sys !== BRING) begin errors++; $display("FAIL lol_release got %0d exp %0d", n_sys, BRING); end
        end
    endtask

    task automatic test_force_run();
        int n;
        int n_low;
        int n_sys;
        // Forced relock while locked: no loss counted, lock already synchronized.
        repeat (int'($urandom_range(1, 6))) @(negedge refclk);
        bus.force_relock = 1'b1;
        @(negedge refclk);
        bus.force_relock = 1'b0;
        checks++; if (bus.pll_rst !== 1'b1 || bus.sys_reset_n !== 1'b0) begin errors++; $display("FAIL force_run_entry got %b%b exp 10", bus.pll_rst, bus.sys_reset_n); end
        checks++; if (int'(bus.relock_count) !== relock_exp) begin errors++; $display("FAIL force_run_relock got %0d exp %0d", bus.relock_count, relock_exp); end
        wait_sig(SEL_PLL_RST, 1'b0, 50, n);
        checks++; if (n !== RST_CYCLES) begin errors++; $display("FAIL force_run_pll_rst_len got %0d exp %0d", n, RST_CYCLES); end
        wait_sig(SEL_SYS, 1'b1, 60, n);
        checks++; if (n !== LOCK_STABLE + 1) begin errors++; $display("FAIL force_run_release got %0d exp %0d", n, LOCK_STABLE + 1); end

        // Force in the same cycle the lock loss reaches the FSM.
        bus.pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        bus.force_relock = 1'b1;
        @(negedge refclk);
        bus.force_relock = 1'b0;
        relock_exp = (relock_exp < 255) ? relock_exp + 1 : 255;
        checks++; if (bus.pll_rst !== 1'b1 || bus.sys_reset_n !== 1'b0) begin errors++; $display("FAIL force_lol_entry got %b%b exp 10", bus.pll_rst, bus.sys_reset_n); end
        checks++; if (int'(bus.relock_count) !== relock_exp) begin errors++; $display("FAIL force_lol_relock got %0d exp %0d", bus.relock_count, relock_exp); end
        run_to_lock(int'($urandom_range(0, 15)), n_low, n_sys);
        checks++; if (n_low !== RST_CYCLES) begin errors++; $display("FAIL force_lol_pll_rst_len got %0d exp %0d", n_low, RST_CYCLES); end
        checks++; if (n_sys !== BRING) begin errors++; $display("FAIL force_lol_release got %0d exp %0d", n_sys, BRING); end
    endtask

    task automatic test_chatter();
        int n;
        int s;
        int len;
        bit seen;
        bus.pll_locked = 1'b0;
        wait_sig(SEL_SYS, 1'b0, 10, n);
        relock_exp = (relock_exp < 255) ? relock_exp + 1 : 255;
        wait_sig(SEL_PLL_RST, 1'b0, 50, n);
        checks++; if (n !== RST_CYCLES) begin errors++; $display("FAIL chatter_pll_rst_len got %0d exp %0d", n, RST_CYCLES); end
        bus.pll_locked = 1'b1;
        s    = int'($urandom_range(0, 5));
        len  = int'($urandom_range(1, 3));
        seen = 1'b0;
        // Third negedge after the lock rise is stable cycle 0; drop at stable cycle s.
        repeat (3 + s) begin
            @(negedge refclk);
            if (bus.sys_reset_n !== 1'b0) seen = 1'b1;
        end
        bus.pll_locked = 1'b0;
        repeat (len) begin
            @(negedge refclk);
            if (bus.sys_reset_n !== 1'b0) seen = 1'b1;
        end
        bus.pll_locked = 1'b1;
        wait_sig(SEL_SYS, 1'b1, 60, n);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL chatter_early_release got %b exp 0 (s=%0d len=%0d)", seen, s, len); end
        checks++; if (n !== BRING) begin errors++; $display("FAIL chatter_release got %0d exp %0d (s=%0d len=%0d)", n, BRING, s, len); end
        checks++; if (int'(bus.relock_count) !== relock_exp) begin errors++; $display("FAIL chatter_relock got %0d exp %0d", bus.relock_count, relock_exp); end
    endtask

    task automatic test_retry_fail();
        int n;
        bus.pll_locked = 1'b0;
        wait_sig(SEL_SYS, 1'b0, 10, n);
        relock_exp = (relock_exp < 255) ? relock_exp + 1 : 255;
        checks++; if (n !== DROP) begin errors++; $display("FAIL retry_sys_fall got %0d exp %0d", n, DROP); end
        for (int p = 0; p <= MAX_RETRIES; p++) begin
            wait_sig(SEL_PLL_RST, 1'b0, 50, n);
            checks++; if (n !== RST_CYCLES) begin errors++; $display("FAIL retry_pulse%0d_len got %0d exp %0d", p, n, RST_CYCLES); end
            wait_sig(SEL_RSTFAIL, 1'b1, 100, n);
            checks++; if (n !== LOCK_TIMEOUT) begin errors++; $display("FAIL retry_wait%0d_len got %0d exp %0d", p, n, LOCK_TIMEOUT); end
            checks++; if (bus.fail !== (p == MAX_RETRIES)) begin errors++; $display("FAIL retry_fail%0d got %b exp %b", p, bus.fail, p == MAX_RETRIES); end
        end
        for (int c = 0; c < 200; c++) begin
            checks++;
            if (bus.fail !== 1'b1 || bus.pll_rst !== 1'b0 || bus.sys_reset_n !== 1'b0 || bus.lock_ok !== 1'b0) begin
                errors++;
                $display("FAIL fail_hold c=%0d got fail/pll_rst/sys/lock %b%b%b%b exp 1000", c, bus.fail, bus.pll_rst, bus.sys_reset_n, bus.lock_ok);
            end
            @(negedge refclk);
        end
    endtask

    task automatic test_force_from_fail();
        int n;
        bus.pll_locked = 1'b1;
        repeat (5) @(negedge refclk);
        checks++; if (bus.fail !== 1'b1) begin errors++; $display("FAIL fail_sticky got %b exp 1", bus.fail); end
        bus.force_relock = 1'b1;
        @(negedge refclk);
        bus.force_relock = 1'b0;
        checks++; if (bus.fail !== 1'b0 || bus.pll_rst !== 1'b1) begin errors++; $display("FAIL ffail_entry got fail/pll_rst %b%b exp 01", bus.fail, bus.pll_rst); end
        checks++; if (int'(bus.relock_count) !== relock_exp) begin errors++; $display("FAIL ffail_relock got %0d exp %0d", bus.relock_count, relock_exp); end
        wait_sig(SEL_PLL_RST, 1'b0, 50, n);
        checks++; if (n !== RST_CYCLES) begin errors++; $display("FAIL ffail_pll_rst_len got %0d exp %0d", n, RST_CYCLES); end
        wait_sig(SEL_SYS, 1'b1, 60, n);
        checks++; if (n !== LOCK_STABLE + 1) begin errors++; $display("FAIL ffail_release got %0d exp %0d", n, LOCK_STABLE + 1); end
    endtask

    task automatic test_saturation();
        int n;
        int n_low;
        int n_sys;
        int iters;
        iters = 255 - relock_exp + 3;
        for (int i = 0; i < iters; i++) begin
            bus.pll_locked = 1'b0;
            wait_sig(SEL_SYS, 1'b0, 10, n);
            relock_exp = (relock_exp < 255) ? relock_exp + 1 : 255;
            checks++; if (int'(bus.relock_count) !== relock_exp) begin errors++; $display("FAIL sat_relock i=%0d got %0d exp %0d", i, bus.relock_count, relock_exp); end
            run_to_lock(0, n_low, n_sys);
            checks++; if (n_sys !== BRING) begin errors++; $display("FAIL sat_release i=%0d got %0d exp %0d", i, n_sys, BRING); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        int n_low;
        int n_sys;
        bus.pll_locked   = 1'b0;
        bus.force_relock = 1'b1;
        @(negedge refclk);
        bus.force_relock = 1'b0;
        wait_sig(SEL_PLL_RST, 1'b0, 50, n);
        bus.pll_locked = 1'b1;
        // Stable cycle 3: three negedges to enter STABLE, three more inside it.
        repeat (6) @(negedge refclk);
        checks++; if (bus.pll_rst !== 1'b0 || bus.sys_reset_n !== 1'b0) begin errors++; $display("FAIL areset_pre got pll_rst/sys %b%b exp 00", bus.pll_rst, bus.sys_reset_n); end
        #2;
        rst_n = 1'b0;
        #1;
        relock_exp = 0;
        checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL areset_pll_rst got %b exp 1", bus.pll_rst); end
        checks++; if (bus.sys_reset_n !== 1'b0 || bus.lock_ok !== 1'b0) begin errors++; $display("FAIL areset_sys_lock got %b%b exp 00", bus.sys_reset_n, bus.lock_ok); end
        checks++; if (bus.fail !== 1'b0) begin errors++; $display("FAIL areset_fail got %b exp 0", bus.fail); end
        checks++; if (int'(bus.relock_count) !== relock_exp) begin errors++; $display("FAIL areset_relock got %0d exp %0d", bus.relock_count, relock_exp); end
        bus.pll_locked = 1'b0;
        @(negedge refclk);
        rst_n = 1'b1;
        wait_sig(SEL_PLL_RST, 1'b0, 50, n);
        checks++; if (n !== 1 + RST_CYCLES) begin errors++; $display("FAIL areset_pll_rst_len got %0d exp %0d", n, 1 + RST_CYCLES); end
        run_to_lock(int'($urandom_range(0, 15)), n_low, n_sys);
        checks++; if (n_sys !== BRING) begin errors++; $display("FAIL areset_release got %0d exp %0d", n_sys, BRING); end
        checks++; if (int'(bus.relock_count) !== relock_exp) begin errors++; $display("FAIL areset_relock_after got %0d exp %0d", bus.relock_count, relock_exp); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_loss_of_lock();
        test_force_run();
        test_chatter();
        test_retry_fail();
        test_force_from_fail();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
